// File: rtl/cpu_cmd_pkg.sv
// Command field layout shared by FETCH/WRITE, the command queue and DECODE.
// Packed order is {data, addr, opcode} with the opcode in the LSBs.
package cpu_cmd_pkg;

    localparam int CMD_DATA_W   = 14;
    localparam int CMD_ADDR_W   = 12;
    localparam int CMD_OPCODE_W = 4;
    localparam int CMD_W        = CMD_DATA_W + CMD_ADDR_W + CMD_OPCODE_W;

    localparam int CMD_OPCODE_LSB = 0;
    localparam int CMD_ADDR_LSB   = CMD_OPCODE_LSB + CMD_OPCODE_W;
    localparam int CMD_DATA_LSB   = CMD_ADDR_LSB + CMD_ADDR_W;

    typedef struct packed {
        logic [CMD_DATA_W-1:0]   data;
        logic [CMD_ADDR_W-1:0]   addr;
        logic [CMD_OPCODE_W-1:0] opcode;
    } cmd_t;

endpackage

// File: rtl/cmd_queue_ptr.sv
// Queue pointer with wrap bit: increments on inc, loads load_val on load.
// Updates on the falling clock edge; load wins over inc; no backpressure of its own.
// Reset (async, active-low) returns the pointer to zero.
module cmd_queue_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = load_val;
        end else if (inc) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/command_queue.sv
// Command FIFO from FETCH/WRITE to DECODE with first-word-fall-through head.
// Latency: a word written at falling edge N is visible at the head from edge N.
// Backpressure: wr_ready = !full (no rd_ready path), rd_valid = !empty; flush wins.
module command_queue
    import cpu_cmd_pkg::*;
#(
    parameter int DATA_FIELD_W = CMD_DATA_W,
    parameter int ADDR_W       = CMD_ADDR_W,
    parameter int OPCODE_W     = CMD_OPCODE_W,
    parameter int DEPTH        = 16,
    parameter int AFULL_LVL    = DEPTH - 2,
    localparam int CMDW        = DATA_FIELD_W + ADDR_W + OPCODE_W,
    localparam int PTR_W       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid,
    input  logic [CMDW-1:0]         wr_cmd,
    output logic                    wr_ready,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_FIELD_W-1:0] rd_data,
    output logic [ADDR_W-1:0]       rd_addr,
    output logic [OPCODE_W-1:0]     rd_opcode,
    input  logic                    flush,
    output logic [PTR_W:0]          count,
    output logic                    almost_full,
    output logic                    pause_WRITE,
    output logic                    pause_DECODE,
    output logic                    err,
    input  logic                    err_clr
);

    localparam int OPC_LSB  = 0;
    localparam int ADDR_LSB = OPCODE_W;
    localparam int DATA_LSB = OPCODE_W + ADDR_W;
    localparam logic [PTR_W:0] AFULL_CNT = (PTR_W + 1)'(AFULL_LVL);

    logic [CMDW-1:0] mem_q [DEPTH];
    logic [PTR_W:0]  wr_ptr;
    logic [PTR_W:0]  rd_ptr;
    logic [CMDW-1:0] head;
    logic            full;
    logic            empty;
    logic            wr_en;
    logic            rd_en;
    logic            err_q;
    logic            err_d;

    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
        wr_en = wr_valid && !full && !flush;
        rd_en = rd_ready && !empty && !flush;
    end

    // Flush drops the same-cycle write and moves the read pointer onto the write pointer.
    cmd_queue_ptr #(.W(PTR_W + 1)) u_wr_ptr (
        .clk      (clk),
        .reset    (reset),
        .inc      (wr_en),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (wr_ptr)
    );

    cmd_queue_ptr #(.W(PTR_W + 1)) u_rd_ptr (
        .clk      (clk),
        .reset    (reset),
        .inc      (rd_en),
        .load     (flush),
        .load_val (wr_ptr),
        .ptr      (rd_ptr)
    );

    always_ff @(negedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr[PTR_W-1:0]] <= wr_cmd;
        end
    end

    // err_clr outranks a new error; a flush cycle never flags one.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end else if (!flush && ((wr_valid && full) || (rd_ready && empty))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    always_comb begin
        head      = mem_q[rd_ptr[PTR_W-1:0]];
        rd_data   = head[DATA_LSB +: DATA_FIELD_W];
        rd_addr   = head[ADDR_LSB +: ADDR_W];
        rd_opcode = head[OPC_LSB +: OPCODE_W];
    end

    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = (count >= AFULL_CNT);
    assign wr_ready     = !full;
    assign rd_valid     = !empty;
    assign pause_WRITE  = full;
    assign pause_DECODE = empty;
    assign err          = err_q;

endmodule
